fifo_egress_arbiter: RTL
========================

// Module: fifo_egress_arbiter
// PURPOSE
//   Shares one egress stream between NUM_PORTS ingress synchronous_fifo instances (FWFT mode).
//   Packet-aware round-robin: a grant is held from the first word to the word whose last flag is set.
//   Registered output with valid/ready handshake; packets never interleave. Overlength packets are
//   truncated and their remainder discarded.
// PARAMETERS
//   NUM_PORTS         4    ingress FIFOs arbitrated; must be >= 2
//   DATA_WIDTH        16   payload bits; FIFO word is DATA_WIDTH+1 bits, MSB = last flag
//   MAX_PACKET_WORDS  1024 longest legal packet in words; must be >= 2
// PORTS
//   clock                 in   1                        system clock, all logic on rising edge
//   reset                 in   1                        synchronous, active-high
//   fifo_read_data        in   NUM_PORTS*(DATA_WIDTH+1) FIFO head words; port p at [p*(DATA_WIDTH+1) +: DATA_WIDTH+1]
//   fifo_read_data_valid  in   NUM_PORTS                FIFO head word valid, i.e. FIFO not empty
//   fifo_read_enable      out  NUM_PORTS                pop the head word of FIFO p
//   output_data           out  DATA_WIDTH               egress payload
//   output_last           out  1                        final word of the packet
//   output_valid          out  1                        output_data and output_last are valid
//   output_ready          in   1                        downstream accepts the word this cycle
//   grant_port            out  $clog2(NUM_PORTS)        currently or last granted port
//   busy                  out  1                        high in TRANSFER or DISCARD
//   truncation_error      out  1                        one-cycle pulse when a packet is truncated
// BEHAVIOUR
//   Reset:
//   - output_valid, output_last, output_data, busy, truncation_error, fifo_read_enable = 0.
//   - State = IDLE; grant_port = 0; last_grant = NUM_PORTS-1, so port 0 wins the first arbitration.
//   Output register:
//   - space = !output_valid | output_ready.
//   - output_valid clears when output_ready=1 and no new word loads.
//   - While output_valid=1 and output_ready=0, output_data and output_last hold.
//   FSM IDLE:
//   - If any fifo_read_data_valid=1, grant = first valid port searching from last_grant+1 mod NUM_PORTS.
//   - Go to TRANSFER with word_count = 0. No pops in IDLE (one bubble cycle per packet).
//   FSM TRANSFER:
//   - pop = fifo_read_data_valid[grant] & space; fifo_read_enable[grant] = pop (combinational).
//   - All other read enables stay 0.
//   - On pop: output register loads the head word, output_valid=1, word_count++.
//   - Popped word has last=1: go to IDLE, last_grant = grant.
//   - Popped word has last=0 and word_count == MAX_PACKET_WORDS-1:
//     output_last is forced to 1, truncation_error pulses 1 cycle, go to DISCARD.
//   - Granted FIFO empties mid-packet: wait in TRANSFER with no timeout; other ports are not served.
//   FSM DISCARD:
//   - fifo_read_enable[grant] = fifo_read_data_valid[grant], independent of output_ready; nothing is loaded.
//   - Popped word has last=1: go to IDLE, last_grant = grant.
//   Widths and edge cases:
//   - word_count width is $clog2(MAX_PACKET_WORDS+1). Round-robin pointer wraps NUM_PORTS-1 -> 0.
//   - A 1-word packet (last on the first word) is legal.
//   - reset asserted mid-packet: next cycle all state is back at reset values; words already popped are lost.
//   - fifo_read_enable is never asserted for a port whose fifo_read_data_valid=0.
// TESTING
//   1 Reset: hold reset 3 cycles -> all outputs 0; port 1 alone holds a packet -> grant_port=1,
//     first word valid 2 cycles after reset drops.
//   2 Ports 0 and 2 each hold 3-word packets, output_ready=1 -> port 0's 3 words, then 1 bubble cycle,
//     then port 2's 3 words; output_last only on words 3 and 6.
//   3 All 4 ports hold 1-word packets continuously -> grant sequence 0,1,2,3,0,1 with no starvation.
//   4 output_ready=0 for 5 cycles mid-packet -> output_data stable, no fifo_read_enable, no word lost or duplicated.
//   5 MAX_PACKET_WORDS=8, port 0 sends a 10-word packet, then port 1 sends a 2-word packet -> 8 words out,
//     word 8 with output_last=1, truncation_error pulses once, words 9-10 popped and dropped,
//     then port 1's packet is intact.
//   6 Assert reset while word 2 of 5 is in flight -> output_valid=0 and busy=0 next cycle;
//     after release, arbitration restarts at port 0.

Source files
------------

// File: rtl/fifo_egress_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_egress_arbiter_if
//   Bundles the ingress-FIFO read side and the egress valid/ready stream of
//   fifo_egress_arbiter.
//   master : the arbiter (reads FIFO heads, pops them, drives the egress word)
//   slave  : the environment (FIFOs present head words, downstream gives ready)
// Signals
//   fifo_read_data        NUM_PORTS*(DATA_WIDTH+1) FIFO head words, MSB = last
//   fifo_read_data_valid  NUM_PORTS                FIFO p not empty
//   fifo_read_enable      NUM_PORTS                pop head word of FIFO p
//   output_data           DATA_WIDTH               egress payload
//   output_last           1                        final word of packet
//   output_valid          1                        egress word valid
//   output_ready          1                        downstream accepts word
// ---------------------------------------------------------------------------
interface fifo_egress_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_PORTS*(DATA_WIDTH+1)-1:0] fifo_read_data;
    logic [NUM_PORTS-1:0]                fifo_read_data_valid;
    logic [NUM_PORTS-1:0]                fifo_read_enable;
    logic [DATA_WIDTH-1:0]               output_data;
    logic                                output_last;
    logic                                output_valid;
    logic                                output_ready;

    modport master (
        input  fifo_read_data,
        input  fifo_read_data_valid,
        input  output_ready,
        output fifo_read_enable,
        output output_data,
        output output_last,
        output output_valid
    );

    modport slave (
        output fifo_read_data,
        output fifo_read_data_valid,
        output output_ready,
        input  fifo_read_enable,
        input  output_data,
        input  output_last,
        input  output_valid
    );
endinterface

// File: rtl/fifo_egress_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_egress_arbiter
//   Shares one registered egress stream between NUM_PORTS first-word-fall-
//   through ingress FIFOs. Arbitration is packet-aware round-robin: once a
//   port is granted it keeps the grant until the word carrying the last flag
//   has been popped, so packets never interleave. Packets longer than
//   MAX_PACKET_WORDS are cut: the last word sent is marked last, a one-cycle
//   truncation_error pulse is raised, and the rest of the packet is popped
//   and dropped.
// Ports
//   clock             system clock, rising edge
//   reset             synchronous, active-high
//   bus               fifo_egress_arbiter_if.master (FIFO read side + egress)
//   grant_port        currently or most recently granted port
//   busy              high while a packet is being transferred or discarded
//   truncation_error  one-cycle pulse alongside a truncated final word
// ---------------------------------------------------------------------------
module fifo_egress_arbiter #(
    parameter int NUM_PORTS        = 4,
    parameter int DATA_WIDTH       = 16,
    parameter int MAX_PACKET_WORDS = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    fifo_egress_arbiter_if.master        bus,
    output logic [$clog2(NUM_PORTS)-1:0] grant_port,
    output logic                         busy,
    output logic                         truncation_error
);

    localparam int WW = DATA_WIDTH + 1;
    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(MAX_PACKET_WORDS + 1);
    localparam logic [CW-1:0] CNT_TRUNC = CW'(MAX_PACKET_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRANSFER = 2'd1,
        DISCARD  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          grant_q, grant_d;
    logic [PW-1:0]          last_grant_q, last_grant_d;
    logic [CW-1:0]          word_count_q, word_count_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic                   out_valid_q, out_valid_d;
    logic                   trunc_q, trunc_d;

    logic [WW-1:0]          words [NUM_PORTS];
    logic [WW-1:0]          head_word;
    logic                   head_valid;
    logic                   head_last;
    logic                   space;
    logic                   pop;
    logic                   load;
    logic                   trunc_now;
    logic [NUM_PORTS-1:0]   rd_en;
    logic                   any_valid;
    logic [PW-1:0]          rr_pick;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_words
        assign words[p] = bus.fifo_read_data[p*WW +: WW];
    end

    assign head_word  = words[grant_q];
    assign head_valid = bus.fifo_read_data_valid[grant_q];
    assign head_last  = head_word[WW-1];
    assign space      = !out_valid_q || bus.output_ready;
    assign any_valid  = |bus.fifo_read_data_valid;

    // Round-robin pick: first requesting port after the last completed grant.
    always_comb begin
        logic found;
        found   = 1'b0;
        rr_pick = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            logic [PW-1:0] idx;
            idx = PW'((int'(last_grant_q) + i) % NUM_PORTS);
            if (!found && bus.fifo_read_data_valid[idx]) begin
                found   = 1'b1;
                rr_pick = idx;
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= PW'(NUM_PORTS - 1);
            word_count_q <= '0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            word_count_q <= word_count_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            trunc_q      <= trunc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        word_count_d = word_count_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d      = rr_pick;
                    word_count_d = '0;
                    state_d      = TRANSFER;
                end
            end
            TRANSFER: begin
                if (pop) begin
                    word_count_d = word_count_q + 1'b1;
                    if (head_last) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end else if (word_count_q == CNT_TRUNC) begin
                        state_d = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (pop && head_last) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: FIFO pops and the egress register load.
    // No pop while reset is asserted, so the reset cycle never consumes a word.
    always_comb begin
        pop       = 1'b0;
        load      = 1'b0;
        trunc_now = 1'b0;
        rd_en     = '0;
        case (state_q)
            TRANSFER: begin
                pop       = head_valid && space && !reset;
                load      = pop;
                trunc_now = pop && !head_last && (word_count_q == CNT_TRUNC);
            end
            DISCARD: begin
                // Dropped words never reach the egress register, so ready is irrelevant.
                pop = head_valid && !reset;
            end
            default: ;
        endcase
        rd_en[grant_q] = pop;

        out_valid_d = load || (out_valid_q && !bus.output_ready);
        out_data_d  = load ? head_word[DATA_WIDTH-1:0] : out_data_q;
        out_last_d  = load ? (head_last || trunc_now) : out_last_q;
        trunc_d     = trunc_now;
    end

    assign bus.fifo_read_enable = rd_en;
    assign bus.output_data      = out_data_q;
    assign bus.output_last      = out_last_q;
    assign bus.output_valid     = out_valid_q;
    assign grant_port           = grant_q;
    assign busy                 = (state_q != IDLE);
    assign truncation_error     = trunc_q;

endmodule
